int_to_float_converter: RTL and testbench

Memory-mapped converter that turns a 32-bit two's-complement integer into an IEEE-754 single-precision float. It sits directly upstream of the floating-point adder on the same data bus: software writes an integer, polls status, and reads back the float to store into the adder's operand registers. Conversion is iterative: one normalisation shift per cycle, then a round-to-nearest-even step.

---
 rtl/int_to_float_converter.sv | 117 +++++++++++
 tb/tb_int_to_float_converter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/int_to_float_converter.sv
// int_to_float_converter
//   Memory-mapped 32-bit two's-complement integer -> IEEE-754 single converter.
//   Software writes the integer to BASE_ADDR, polls status at BASE_ADDR+4 and
//   reads the float from BASE_ADDR+8. Normalisation moves one bit per cycle,
//   followed by one round-to-nearest-even cycle.
// Ports:
//   clk        system clock; state on rising edge, Result on falling edge
//   reset      asynchronous, active-high
//   Data_Addr  bus address
//   Data_In    bus write data
//   MemWrite   bus write strobe
//   Result     registered bus read data
//   Busy       high while a conversion is in progress
module int_to_float_converter #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0498
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Data_Addr,
    input  logic [31:0] Data_In,
    input  logic        MemWrite,
    output logic [31:0] Result,
    output logic        Busy
);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t      state;
    logic        sign;
    logic [31:0] mag;
    logic [7:0]  exp;
    logic [31:0] res;
    logic        done;

    logic        start;
    logic [31:0] abs_in;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [24:0] mant_inc;

    // Writes during NORM/ROUND are dropped so the conversion in flight survives.
    assign start  = MemWrite && (Data_Addr == BASE_ADDR) &&
                    (state == IDLE || state == DONE);
    // 0x80000000 negates to itself, which is exactly the unsigned magnitude.
    assign abs_in = Data_In[31] ? (~Data_In + 32'd1) : Data_In;

    // Round-to-nearest-even on the normalised magnitude.
    assign guard    = mag[7];
    assign sticky   = |mag[6:0];
    assign round_up = guard && (sticky || mag[8]);
    assign mant_inc = {1'b0, mag[31:8]} + {24'd0, round_up};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sign  <= 1'b0;
            mag   <= 32'd0;
            exp   <= 8'd0;
            res   <= 32'd0;
            done  <= 1'b0;
            Busy  <= 1'b0;
        end else begin
            if (start) begin
                if (Data_In == 32'd0) begin
                    res   <= 32'd0;
                    done  <= 1'b1;
                    state <= DONE;
                    Busy  <= 1'b0;
                end else begin
                    sign  <= Data_In[31];
                    mag   <= abs_in;
                    exp   <= 8'd158;
                    done  <= 1'b0;
                    state <= NORM;
                    Busy  <= 1'b1;
                end
            end else begin
                case (state)
                    NORM: begin
                        if (mag[31]) begin
                            state <= ROUND;
                        end else begin
                            mag <= mag << 1;
                            exp <= exp - 8'd1;
                        end
                    end
                    ROUND: begin
                        // Carry out of 24 bits: mantissa wraps to 1.0, exponent bumps.
                        if (mant_inc[24])
                            res <= {sign, exp + 8'd1, 23'd0};
                        else
                            res <= {sign, exp, mant_inc[22:0]};
                        done  <= 1'b1;
                        state <= DONE;
                        Busy  <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Read data is presented half a cycle after the state it reflects.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            Result <= 32'd0;
        end else if (Data_Addr == BASE_ADDR + 32'd4) begin
            Result <= {30'd0, done, Busy};
        end else if (Data_Addr == BASE_ADDR + 32'd8) begin
            Result <= res;
        end else begin
            Result <= 32'd0;
        end
    end

endmodule

// File: tb/tb_int_to_float_converter.sv
module tb_int_to_float_converter;

    localparam logic [31:0] BASE = 32'h0000_0498;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Data_Addr;
    logic [31:0] Data_In;
    logic        MemWrite;
    logic [31:0] Result;
    logic        Busy;

    int checks = 0;
    int errors = 0;

    int_to_float_converter #(.BASE_ADDR(BASE)) dut (
        .clk      (clk),
        .reset    (reset),
        .Data_Addr(Data_Addr),
        .Data_In  (Data_In),
        .MemWrite (MemWrite),
        .Result   (Result),
        .Busy     (Busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Reference: exact integer value rounded to 24 significant bits (RNE),
    // plus the latency implied by the position of the leading one.
    task automatic ref_model(input logic [31:0] x, output logic [31:0] f, output int lat);
        longint m, q, rem, half;
        int p, sh;
        logic s;
        s = x[31];
        m = s ? (64'sd4294967296 - longint'(x)) : longint'(x);
        if (m == 0) begin
            f = 32'd0;
            lat = 0;
            return;
        end
        p = 0;
        for (int i = 0; i < 33; i++) if ((m >> i) != 0) p = i;
        lat = (31 - p) + 2;
        if (p <= 23) begin
            q = m << (23 - p);
        end else begin
            sh   = p - 23;
            q    = m >> sh;
            rem  = m - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
            if (q == (longint'(1) << 24)) begin
                q = longint'(1) << 23;
                p++;
            end
        end
        f = {s, 8'(p + 127), q[22:0]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_at_negedge(input logic [31:0] addr, output logic [31:0] v);
        Data_Addr = addr;
        @(negedge clk);
        #1;
        v = Result;
    endtask

    task automatic convert(input logic [31:0] x, input string tag);
        logic [31:0] expf, v;
        int lat;
        ref_model(x, expf, lat);
        Data_Addr = BASE;
        Data_In   = x;
        MemWrite  = 1'b1;
        tick();                       // start edge
        MemWrite  = 1'b0;
        if (lat == 0) begin
            check({tag, " busy0"}, {31'd0, Busy}, 32'd0);
        end else begin
            repeat (lat - 1) tick();
            check({tag, " busy_pre"}, {31'd0, Busy}, 32'd1);
            read_at_negedge(BASE + 4, v);
            check({tag, " status_pre"}, v, 32'd1);
            tick();
            check({tag, " busy_post"}, {31'd0, Busy}, 32'd0);
        end
        read_at_negedge(BASE + 4, v);
        check({tag, " status"}, v, 32'd2);
        read_at_negedge(BASE + 8, v);
        check({tag, " result"}, v, expf);
        tick();
    endtask

    initial begin
        logic [31:0] v, x;
        reset = 1'b1; Data_Addr = 32'd0; Data_In = 32'd0; MemWrite = 1'b0;
        #2;
        check("reset busy", {31'd0, Busy}, 32'd0);
        check("reset result", Result, 32'd0);
        tick();
        reset = 1'b0;
        read_at_negedge(BASE + 4, v);
        check("idle status", v, 32'd0);
        read_at_negedge(BASE + 8, v);
        check("idle result", v, 32'd0);
        read_at_negedge(32'h0000_1000, v);
        check("other addr", v, 32'd0);

        // Directed cases, with the spec's expected constants checked too.
        convert(32'h0000_0005, "five");
        check("five const", Result, 32'h40A0_0000);
        convert(32'hFFFF_FFFD, "minus3");
        check("minus3 const", Result, 32'hC040_0000);
        convert(32'h8000_0000, "intmin");
        check("intmin const", Result, 32'hCF00_0000);
        convert(32'h0000_0000, "zero");
        convert(32'h0100_0001, "tie_even");
        check("tie_even const", Result, 32'h4B80_0000);
        convert(32'h0100_0003, "tie_odd");
        check("tie_odd const", Result, 32'h4B80_0002);
        convert(32'h7FFF_FFFF, "carry");
        check("carry const", Result, 32'h4F00_0000);
        convert(32'hFFFF_FFFF, "minus1");

        // Write during conversion is ignored.
        Data_Addr = BASE; Data_In = 32'd1; MemWrite = 1'b1;
        tick();
        MemWrite = 1'b0;
        tick(); tick();
        Data_In = 32'd7; MemWrite = 1'b1;
        tick();
        MemWrite = 1'b0;
        repeat (29) tick();
        check("ign busy_pre", {31'd0, Busy}, 32'd1);
        tick();
        check("ign busy_post", {31'd0, Busy}, 32'd0);
        read_at_negedge(BASE + 8, v);
        check("ign result", v, 32'h3F80_0000);

        // Reset mid-conversion.
        Data_Addr = BASE; Data_In = 32'd1; MemWrite = 1'b1;
        tick();
        MemWrite = 1'b0;
        Data_Addr = BASE + 4;
        repeat (5) tick();
        reset = 1'b1;
        #1;
        check("rst busy", {31'd0, Busy}, 32'd0);
        check("rst result", Result, 32'd0);
        tick();
        reset = 1'b0;
        read_at_negedge(BASE + 4, v);
        check("rst status", v, 32'd0);
        convert(32'h0000_0002, "two");
        check("two const", Result, 32'h4000_0000);

        // Random magnitudes spread over all leading-zero counts.
        for (int i = 0; i < 40; i++) begin
            x = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) x = -x;
            convert(x, $sformatf("rnd%0d_%h", i, x));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
